// File: rtl/alu_arbiter.sv
// alu_arbiter
//
// Purpose: shares one single-cycle RV32 integer ALU between two requesters
// (port 0 = execute stage, port 1 = address/branch helper). It selects one
// request per cycle with round-robin arbitration. The chosen request drives
// the ALU. The result is captured in a one-entry response register that
// honours backpressure. For shift ops only B[4:0] reaches the ALU. Op codes
// outside the ten defined ones produce a zero result with the illegal flag set.
//
// Configuration macro: ALU_ARB_FIXED_PRIO_EN
//   defined   -> port 0 always wins a contested cycle (port 1 may starve)
//   undefined -> round-robin using the `last` pointer (default)
//
// Parameters:
//   RESET_PRIO   port that wins the first contested grant after reset (0/1)
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   req0_valid/ready/a/b/op     port 0 request handshake and payload
//   req1_valid/ready/a/b/op     port 1 request handshake and payload
//   rsp_valid/rsp_ready         response handshake
//   rsp_id                      port that issued the held response
//   rsp_result                  ALU result (0 for illegal ops)
//   rsp_zero                    rsp_result == 0
//   rsp_illegal                 op code was not a defined ALU op

module alu_core (
   input  logic [3:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] result
);
   logic signed [31:0] a_s;
   logic signed [31:0] b_s;

   assign a_s = a;
   assign b_s = b;

   always_comb begin
      result = '0;
      case (op)
         4'b0000: result = a + b;
         4'b1000: result = a - b;
         4'b0100: result = a ^ b;
         4'b0110: result = a | b;
         4'b0111: result = a & b;
         4'b0001: result = a << b[4:0];
         4'b0101: result = a >> b[4:0];
         4'b1101: result = a_s >>> b[4:0];
         4'b0010: result = {31'b0, (a_s < b_s)};
         4'b0011: result = {31'b0, (a < b)};
         default: result = '0;
      endcase
   end
endmodule

module alu_arbiter #(
   parameter int RESET_PRIO = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic [3:0]  req0_op,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   input  logic [3:0]  req1_op,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [31:0] rsp_result,
   output logic        rsp_zero,
   output logic        rsp_illegal
);
   localparam int DATA_W = 32;

   logic              can_accept;
   logic              grant0;
   logic              grant1;
   logic              accept;
   logic [3:0]        sel_op;
   logic [DATA_W-1:0] sel_a;
   logic [DATA_W-1:0] sel_b;
   logic [DATA_W-1:0] alu_b;
   logic [DATA_W-1:0] alu_result;
   logic [DATA_W-1:0] load_result;
   logic              is_shift;
   logic              illegal;

   // A held response blocks new accepts unless it is consumed this cycle.
   assign can_accept = !rsp_valid || rsp_ready;

`ifdef ALU_ARB_FIXED_PRIO_EN
   assign grant0 = req0_valid;
   assign grant1 = req1_valid && !req0_valid;
`else
   // `last` holds the most recently granted port; on contention the other
   // port wins. Reset loads !RESET_PRIO so RESET_PRIO wins the first contest.
   logic last;

   assign grant0 = req0_valid && (!req1_valid || last);
   assign grant1 = req1_valid && (!req0_valid || !last);

   always_ff @(posedge clk) begin
      if (rst)
         last <= (RESET_PRIO == 0);
      else if (accept)
         last <= grant1;
   end
`endif

   assign req0_ready = can_accept && grant0 && !rst;
   assign req1_ready = can_accept && grant1 && !rst;
   assign accept     = req0_ready || req1_ready;

   assign sel_op = grant1 ? req1_op : req0_op;
   assign sel_a  = grant1 ? req1_a  : req0_a;
   assign sel_b  = grant1 ? req1_b  : req0_b;

   always_comb begin
      illegal  = 1'b0;
      is_shift = 1'b0;
      case (sel_op)
         4'b0001, 4'b0101, 4'b1101:          is_shift = 1'b1;
         4'b0000, 4'b1000, 4'b0100, 4'b0110,
         4'b0111, 4'b0010, 4'b0011:          is_shift = 1'b0;
         default:                            illegal  = 1'b1;
      endcase
   end

   // RV32 shifts use only the low five bits of B.
   assign alu_b = is_shift ? {27'b0, sel_b[4:0]} : sel_b;

   alu_core u_alu (
      .op     (sel_op),
      .a      (sel_a),
      .b      (alu_b),
      .result (alu_result)
   );

   assign load_result = illegal ? '0 : alu_result;

   // Response register: overwritten on accept (even while being consumed),
   // cleared on consume-without-accept, frozen under backpressure.
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid   <= 1'b0;
         rsp_id      <= 1'b0;
         rsp_result  <= '0;
         rsp_zero    <= 1'b0;
         rsp_illegal <= 1'b0;
      end else if (accept) begin
         rsp_valid   <= 1'b1;
         rsp_id      <= grant1;
         rsp_result  <= load_result;
         rsp_zero    <= (load_result == '0);
         rsp_illegal <= illegal;
      end else if (rsp_valid && rsp_ready) begin
         rsp_valid   <= 1'b0;
      end
   end
endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
   localparam int RESET_PRIO = 0;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic [3:0]  req0_op, req1_op;
   logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_illegal;
   logic [31:0] rsp_result;

   int n_cmp = 0;
   int n_bad = 0;

   // Behavioural model state
   bit          m_valid, m_id, m_zero, m_illegal, m_last;
   logic [31:0] m_result;
   bit          m_acc0, m_acc1;

   alu_arbiter #(.RESET_PRIO(RESET_PRIO)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_illegal(rsp_illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference ALU from the op table, using plain arithmetic.
   function automatic void ref_alu(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, output logic [31:0] r,
                                   output bit ill);
      int s;
      s   = int'(b % 32);
      ill = 1'b0;
      case (op)
         4'h0: r = a + b;
         4'h8: r = a - b;
         4'h4: r = a ^ b;
         4'h6: r = a | b;
         4'h7: r = a & b;
         4'h1: r = a << s;
         4'h5: r = a >> s;
         4'hD: r = (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
         4'h2: r = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
         4'h3: r = (a < b) ? 32'd1 : 32'd0;
         default: begin r = 32'h0; ill = 1'b1; end
      endcase
   endfunction

   task automatic model_reset();
      m_valid = 0; m_id = 0; m_result = 0; m_zero = 0; m_illegal = 0;
      m_last = (RESET_PRIO == 0);
   endtask

   // One clock cycle: compare at the falling edge, advance model, then
   // return 1 time unit after the next rising edge, ready for new stimulus.
   task automatic cycle();
      bit          can, a0, a1, ill;
      int          win;
      logic [31:0] r;
      @(negedge clk);
      can = !m_valid || rsp_ready;
      if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
         win = 0;
`else
         win = m_last ? 0 : 1;
`endif
      end else
         win = req1_valid ? 1 : 0;
      a0 = !rst && can && req0_valid && (win == 0);
      a1 = !rst && can && req1_valid && (win == 1);
      chk("req0_ready", req0_ready, a0);
      chk("req1_ready", req1_ready, a1);
      chk("rsp_valid", rsp_valid, m_valid);
      chk("rsp_id", rsp_id, m_id);
      chk("rsp_result", rsp_result, m_result);
      chk("rsp_zero", rsp_zero, m_zero);
      chk("rsp_illegal", rsp_illegal, m_illegal);
      m_acc0 = a0; m_acc1 = a1;
      if (rst)
         model_reset();
      else if (a0 || a1) begin
         if (a1) ref_alu(req1_op, req1_a, req1_b, r, ill);
         else    ref_alu(req0_op, req0_a, req0_b, r, ill);
         m_valid = 1; m_id = a1; m_result = r; m_zero = (r == 0);
         m_illegal = ill; m_last = a1;
      end else if (m_valid && rsp_ready)
         m_valid = 0;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rand_word();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'd1;
         default: return $urandom;
      endcase
   endfunction

   task automatic set0(input bit v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
   endtask

   task automatic set1(input bit v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
   endtask

   logic [31:0] ids [4];
   logic [31:0] exp_ids [4];

   initial begin
      rst = 1; rsp_ready = 1;
      set0(1, 4'h0, 32'd1, 32'd2);
      set1(1, 4'h0, 32'd3, 32'd4);
      @(posedge clk); #1;
      model_reset();

      // Reset held with both ports valid
      cycle(); cycle();
      chk("reset_rsp_valid", rsp_valid, 0);
      chk("reset_rsp_result", rsp_result, 0);
      chk("reset_rsp_id", rsp_id, 0);

      // Single ADD then SUB; port RESET_PRIO wins the first contest
      rst = 0;
      set0(1, 4'h0, 32'd5, 32'd7);
      set1(1, 4'h8, 32'd9, 32'd9);
      cycle();
      chk("add_valid", rsp_valid, 1);
      chk("add_id", rsp_id, 0);
      chk("add_result", rsp_result, 32'd12);
      chk("add_zero", rsp_zero, 0);
      req0_valid = 0;
      cycle();
      chk("sub_id", rsp_id, 1);
      chk("sub_result", rsp_result, 32'd0);
      chk("sub_zero", rsp_zero, 1);

      // Contention with rsp_ready high
      set0(1, 4'h4, 32'hF0F0_0000, 32'h0F0F_0000);
      set1(1, 4'h6, 32'h1, 32'h2);
      for (int k = 0; k < 4; k++) begin
         cycle();
         ids[k] = {31'b0, rsp_id};
      end
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_ids = '{32'd0, 32'd0, 32'd0, 32'd0};
`else
      exp_ids = '{32'd0, 32'd1, 32'd0, 32'd1};
`endif
      for (int k = 0; k < 4; k++) chk("contention_id", ids[k], exp_ids[k]);

      // Backpressure: held response, no accepts
      rsp_ready = 0;
      cycle(); cycle(); cycle();
      rsp_ready = 1;
      cycle();
      chk("bp_release_valid", rsp_valid, 1);

      // Compare / shift / illegal through port 0 alone
      req1_valid = 0;
      set0(1, 4'h2, 32'hFFFF_FFFF, 32'd1);  cycle(); chk("slt", rsp_result, 32'd1);
      set0(1, 4'h3, 32'hFFFF_FFFF, 32'd1);  cycle(); chk("sltu", rsp_result, 32'd0);
      set0(1, 4'h1, 32'd1, 32'h21);         cycle(); chk("sll_mask", rsp_result, 32'd2);
      set0(1, 4'hD, 32'h8000_0000, 32'h24); cycle(); chk("sra_mask", rsp_result, 32'hF800_0000);
      set0(1, 4'hF, 32'd5, 32'd7);          cycle();
      chk("illegal_result", rsp_result, 32'd0);
      chk("illegal_flag", rsp_illegal, 1);
      chk("illegal_zero", rsp_zero, 1);

      // Reset while a response is held
      req0_valid = 0; rsp_ready = 0;
      rst = 1;
      cycle();
      chk("midreset_valid", rsp_valid, 0);
      rst = 0; rsp_ready = 1;

      // Randomized traffic obeying hold-until-ready
      for (int i = 0; i < 3000; i++) begin
         rsp_ready = ($urandom_range(0, 3) != 0);
         rst       = ($urandom_range(0, 199) == 0);
         cycle();
         if (m_acc0 || !req0_valid) begin
            if ($urandom_range(0, 1) == 1)
               set0(1, 4'($urandom_range(0, 15)), rand_word(), rand_word());
            else
               req0_valid = 0;
         end
         if (m_acc1 || !req1_valid) begin
            if ($urandom_range(0, 1) == 1)
               set1(1, 4'($urandom_range(0, 15)), rand_word(), rand_word());
            else
               req1_valid = 0;
         end
      end
      rst = 0;
      cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single-cycle integer ALU between two requesters, the execute stage (port 0) and the address/branch helper (port 1), through valid/ready handshakes. It arbitrates round-robin, drives the ALU, and captures the result in a one-entry response register that supports backpressure. It masks shift amounts to RV32 semantics and flags op codes the ALU does not define. It sits between the issue logic and the shared ALU instance, which it instantiates internally.

## Interface
- RESET_PRIO, default 0: port that wins the first contested grant after reset (0 or 1).
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- req0_valid  in  1  port 0 request present.
- req0_ready  out  1  port 0 request accepted this cycle.
- req0_a  in  32  port 0 operand A.
- req0_b  in  32  port 0 operand B.
- req0_op  in  4  port 0 ALU op code.
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as port 0, for port 1.
- rsp_valid  out  1  response register holds a result.
- rsp_ready  in  1  consumer takes the response this cycle.
- rsp_id  out  1  port that issued the held response.
- rsp_result  out  32  ALU result.
- rsp_zero  out  1  rsp_result == 0.
- rsp_illegal  out  1  op code was not one of the ten defined codes.

## Operation
- Legal op codes: ADD 0000, SUB 1000, XOR 0100, OR 0110, AND 0111, SLL 0001, SRL 0101, SRA 1101, SLT 0010, SLTU 0011. Any other code is illegal.
- can_accept = !rsp_valid | rsp_ready.
- Grant is combinational from the valid signals and a 1-bit `last` pointer:
  - One port valid: that port is granted.
  - Both ports valid: the port not equal to `last` is granted.
- reqN_ready = can_accept & grantN & !rst. At most one ready is high per cycle.
- Shift ops (SLL/SRL/SRA): the ALU receives B as {27'b0, B[4:0]}. All other ops pass B unmodified.
- On an accept (valid & ready), at the next edge:
  - rsp_result is loaded with the ALU output, or with 0 if the op is illegal.
  - rsp_zero = (loaded result == 0).
  - rsp_illegal is loaded; rsp_id = granted port; rsp_valid = 1; `last` = granted port.
- If rsp_valid & rsp_ready and there is no new accept, rsp_valid clears. Data fields hold their last values.
- If rsp_valid & !rsp_ready, all rsp_* outputs hold stable and no request is accepted.
- Requesters must hold valid and payload stable until ready. The arbiter never drops a request that is presented.

## Timing
- Reset values: rsp_valid 0, rsp_id 0, rsp_result 0, rsp_zero 0, rsp_illegal 0, req0_ready 0, req1_ready 0, `last` = !RESET_PRIO.
- Latency: accept at edge N, response visible after edge N with rsp_valid = 1.
- Throughput: one operation per cycle while rsp_ready = 1. Back-to-back accepts are allowed when a response is consumed in the same cycle.
- Simultaneous consume and accept: the response register is overwritten with the new result and rsp_valid stays 1.
- Reset mid-operation: the pending response is discarded with no rsp_valid pulse, and arbitration restarts from RESET_PRIO.
- Illegal op: still occupies one response slot with normal latency.

## Configuration
- ALU_ARB_FIXED_PRIO_EN
  - Defined: port 0 always wins when both ports are valid. `last` and RESET_PRIO are ignored, so port 1 can starve.
  - Undefined (default): round-robin as described above.

## Test plan
- Reset: rst = 1 for 2 cycles with both valid → both ready 0, rsp_valid 0, all rsp_* outputs 0. After release, port RESET_PRIO = 0 is granted first.
- Single ADD: port 0 sends A = 5, B = 7 → next cycle rsp_valid 1, id 0, result 12, zero 0. Port 1 sends SUB 9 − 9 → result 0, zero 1.
- Contention: both ports valid continuously with rsp_ready = 1 → ids 0, 1, 0, 1 on consecutive cycles. With ALU_ARB_FIXED_PRIO_EN defined → ids 0, 0, 0, 0.
- Backpressure: rsp_ready = 0 for 3 cycles with a response held → rsp_* stable and both ready 0. On raising rsp_ready → new accept in the same cycle and the next response one cycle later.
- Compare/shift: SLT A = 0xFFFFFFFF, B = 1 → result 1. SLTU with the same operands → result 0. SLL A = 1, B = 0x21 → result 2.
- Illegal op 4'b1111 → result 0, illegal 1, zero 1. A reset asserted while rsp_valid = 1 → rsp_valid 0 the next cycle.
